// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Synchronous FIFO with watermarks, occupancy count and optional FWFT read.
//  Revision : 1.0
// ============================================================================
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_n,
    input  logic                      rd_n,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      over_flow,
    output logic                      under_flow,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] c_AFULL  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] c_AEMPTY = CW'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_over;
    logic                  r_under;

    logic w_wr;
    logic w_rd;
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_wr    = ~wr_n;
    assign w_rd    = ~rd_n;
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still taken when a read frees the slot on the same edge.
    assign w_wr_acc = w_wr & (~w_full | w_rd);
    assign w_rd_acc = w_rd & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc && rst_n) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_over   <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_over  <= w_wr & w_full & ~w_rd;
            r_under <= w_rd & w_empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
            assign data_out = r_dout;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);
    assign over_flow    = r_over;
    assign under_flow   = r_under;
    assign fifo_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Bench for fifo_sync_param: queue-based reference model plus literal checks.
//  Revision : 1.0
// ============================================================================
module tb_fifo_sync_param;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_n;
    logic          rd_n;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout0, dout1;
    logic          full0, empty0, af0, ae0, of0, uf0;
    logic          full1, empty1, af1, ae1, of1, uf1;
    logic [4:0]    cnt0, cnt1;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AF_LVL),
                      .AEMPTY_LVL(AE_LVL), .FWFT(0)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n), .data_in(data_in),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .over_flow(of0), .under_flow(uf0), .fifo_count(cnt0)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AF_LVL),
                      .AEMPTY_LVL(AE_LVL), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n), .data_in(data_in),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .over_flow(of1), .under_flow(uf1), .fifo_count(cnt1)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: contents as a queue, plus the registered outputs.
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_dout;
    bit            m_of;
    bit            m_uf;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
    endtask

    // Apply one cycle of stimulus from a falling edge to the next falling edge.
    task automatic op(input bit w, input bit r, input logic [DW-1:0] d);
        int  n;
        bit  wr_ok, rd_ok;
        wr_n    = ~w;
        rd_n    = ~r;
        data_in = d;
        @(posedge clk);
        n     = m_q.size();
        rd_ok = r && (n != 0);
        wr_ok = w && ((n != DEPTH) || r);
        m_of  = w && (n == DEPTH) && !r;
        m_uf  = r && (n == 0);
        if (rd_ok) m_dout = m_q.pop_front();
        if (wr_ok) m_q.push_back(d);
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("count",        int'(cnt0),  m_q.size());
                check("full",         int'(full0), int'(m_q.size() == DEPTH));
                check("empty",        int'(empty0), int'(m_q.size() == 0));
                check("almost_full",  int'(af0),   int'(m_q.size() >= AF_LVL));
                check("almost_empty", int'(ae0),   int'(m_q.size() <= AE_LVL));
                check("over_flow",    int'(of0),   int'(m_of));
                check("under_flow",   int'(uf0),   int'(m_uf));
                check("data_out",     int'(dout0), int'(m_dout));
                check("fwft_count",   int'(cnt1),  m_q.size());
                check("fwft_oflow",   int'(of1),   int'(m_of));
                check("fwft_uflow",   int'(uf1),   int'(m_uf));
                if (m_q.size() != 0) check("fwft_head", int'(dout1), int'(m_q[0]));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        rst_n   = 1'b0;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", int'(cnt0), 0);
        check("rst_empty", int'(empty0), 1);
        check("rst_aempty", int'(ae0), 1);
        check("rst_full", int'(full0), 0);
        check("rst_dout", int'(dout0), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, DW'(i));
            check("fill_count", int'(cnt0), i + 1);
            check("fill_afull", int'(af0), int'(i + 1 >= 12));
        end
        check("fill_full", int'(full0), 1);

        // Write when full
        op(1'b1, 1'b0, 8'hAA);
        check("ovf_pulse", int'(of0), 1);
        check("ovf_count", int'(cnt0), 16);
        op(1'b0, 1'b0, 8'h00);
        check("ovf_clear", int'(of0), 0);

        // Drain with one-cycle read latency
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 8'h00);
            check("drain_data", int'(dout0), i);
        end
        check("drain_empty", int'(empty0), 1);
        op(1'b0, 1'b1, 8'h00);
        check("udf_pulse", int'(uf0), 1);
        check("udf_hold", int'(dout0), 8'h0F);
        op(1'b0, 1'b0, 8'h00);
        check("udf_clear", int'(uf0), 0);

        // Simultaneous read/write at empty, full and count 5
        op(1'b1, 1'b1, 8'h30);
        check("rw_empty_count", int'(cnt0), 1);
        check("rw_empty_udf", int'(uf0), 1);
        for (int i = 1; i < 16; i++) op(1'b1, 1'b0, DW'(8'h30 + i));
        op(1'b1, 1'b1, 8'h77);
        check("rw_full_count", int'(cnt0), 16);
        check("rw_full_ovf", int'(of0), 0);
        check("rw_full_data", int'(dout0), 8'h30);
        repeat (11) op(1'b0, 1'b1, 8'h00);
        op(1'b1, 1'b1, 8'h99);
        check("rw_mid_count", int'(cnt0), 5);
        check("rw_mid_data", int'(dout0), 8'h3C);

        // Randomised interleaving, wraps the pointers several times
        for (int i = 0; i < 300; i++) begin
            d = DW'($urandom);
            op(1'(($urandom % 4) != 0), 1'(($urandom % 4) != 0), d);
        end

        // Reset mid-burst, away from a clock edge
        repeat (20) op(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) op(1'b1, 1'b0, DW'(8'h50 + i));
        wr_n = 1'b1;
        check("pre_rst_count", int'(cnt0), 9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_count", int'(cnt0), 0);
        check("async_rst_empty", int'(empty0), 1);
        check("async_rst_dout", int'(dout0), 0);
        check("async_rst_fwft_count", int'(cnt1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FWFT: first word visible without a read
        op(1'b1, 1'b0, 8'h5C);
        check("fwft_first", int'(dout1), 8'h5C);
        check("fwft_first_count", int'(cnt1), 1);
        op(1'b1, 1'b0, 8'h5D);
        op(1'b0, 1'b1, 8'h00);
        check("fwft_advance", int'(dout1), 8'h5D);
        op(1'b0, 1'b0, 8'h00);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
